// File: rtl/ccc_lock_mgr.sv
// ccc_lock_mgr: PLL lock qualification, reset sequencing and per-channel
// clock-enable generation in the conditioned global clock domain.
module ccc_lock_mgr #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 8,
    parameter int LOCK_FILT = 256,
    parameter int RST_HOLD  = 64,
    parameter int LOSS_W    = 8
) (
    input  logic                    CLK,
    input  logic                    ARST_N,
    input  logic                    LOCK_IN,
    input  logic                    SW_RST,
    input  logic [NUM_CH-1:0]       CE_EN,
    input  logic [NUM_CH*DIV_W-1:0] DIV,
    output logic                    RESET_OUT_N,
    output logic                    LOCKED,
    output logic [NUM_CH-1:0]       CE,
    output logic [LOSS_W-1:0]       LOSS_CNT
);

    // Sequence counter is shared by FILTER and HOLD, so it must reach the larger terminal value.
    localparam int CNT_MAX = (LOCK_FILT > RST_HOLD) ? LOCK_FILT : RST_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] FILTER    = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    logic             lock_s1;
    logic             lock_s2;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] seq_cnt;
    logic [CNT_W-1:0] seq_cnt_nxt;
    logic             loss_evt;
    logic             run_q;

    // Lock-loss counter sticks at all-ones instead of wrapping.
    function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
        return (v == {LOSS_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
        end else begin
            lock_s1 <= LOCK_IN;
            lock_s2 <= lock_s1;
        end
    end

    // Next-state decode; lock loss always outranks a software reset request.
    always_comb begin
        state_nxt   = state;
        seq_cnt_nxt = seq_cnt;
        loss_evt    = 1'b0;
        case (state)
            WAIT_LOCK: begin
                seq_cnt_nxt = '0;
                if (lock_s2) state_nxt = FILTER;
            end
            FILTER: begin
                if (!lock_s2) begin
                    state_nxt   = WAIT_LOCK;
                    seq_cnt_nxt = '0;
                end else if (seq_cnt == FILT_LAST) begin
                    state_nxt   = HOLD;
                    seq_cnt_nxt = '0;
                end else begin
                    seq_cnt_nxt = seq_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!lock_s2) begin
                    state_nxt   = WAIT_LOCK;
                    seq_cnt_nxt = '0;
                end else if (SW_RST) begin
                    seq_cnt_nxt = '0;
                end else if (seq_cnt == HOLD_LAST) begin
                    state_nxt   = RUN;
                    seq_cnt_nxt = '0;
                end else begin
                    seq_cnt_nxt = seq_cnt + 1'b1;
                end
            end
            RUN: begin
                seq_cnt_nxt = '0;
                if (!lock_s2) begin
                    state_nxt = WAIT_LOCK;
                    loss_evt  = 1'b1;
                end else if (SW_RST) begin
                    state_nxt = HOLD;
                end
            end
            default: begin
                state_nxt   = WAIT_LOCK;
                seq_cnt_nxt = '0;
            end
        endcase
    end

    // Sequencer state, counter and a dedicated RUN flag so the outputs come straight from a flop.
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state    <= WAIT_LOCK;
            seq_cnt  <= '0;
            run_q    <= 1'b0;
            LOSS_CNT <= '0;
        end else begin
            state   <= state_nxt;
            seq_cnt <= seq_cnt_nxt;
            run_q   <= (state_nxt == RUN);
            if (loss_evt) LOSS_CNT <= sat_inc(LOSS_CNT);
        end
    end

    assign RESET_OUT_N = run_q;
    assign LOCKED      = run_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div_cnt;
        logic [DIV_W-1:0] div_sel;
        logic [DIV_W:0]   cnt_inc;
        logic             wrap;

        // Wrap when cnt >= DIV-1, evaluated one bit wider so DIV=0 needs no special case.
        assign div_sel = DIV[i*DIV_W +: DIV_W];
        assign cnt_inc = {1'b0, div_cnt} + {{DIV_W{1'b0}}, 1'b1};
        assign wrap    = (cnt_inc >= {1'b0, div_sel});

        // Counter sits at 0 outside RUN (including the exit edge) and while disabled, so pulses start aligned.
        always_ff @(posedge CLK or negedge ARST_N) begin
            if (!ARST_N) begin
                div_cnt <= '0;
            end else if (!run_q || (state_nxt != RUN) || !CE_EN[i] || wrap) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= cnt_inc[DIV_W-1:0];
            end
        end

        assign CE[i] = run_q && CE_EN[i] && (div_cnt == '0);
    end

endmodule

// File: tb/tb_ccc_lock_mgr.sv
// tb_ccc_lock_mgr: directed scenarios, a CE divide table and randomized
// traffic, all checked against a phase-level reference model.
module tb_ccc_lock_mgr;

    localparam int NUM_CH    = 4;
    localparam int DIV_W     = 8;
    localparam int LOCK_FILT = 8;
    localparam int RST_HOLD  = 16;
    localparam int LOSS_W    = 8;
    localparam int LOSS_MAX  = (1 << LOSS_W) - 1;

    logic                    CLK = 1'b0;
    logic                    ARST_N;
    logic                    LOCK_IN;
    logic                    SW_RST;
    logic [NUM_CH-1:0]       CE_EN;
    logic [NUM_CH*DIV_W-1:0] DIV;
    logic                    RESET_OUT_N;
    logic                    LOCKED;
    logic [NUM_CH-1:0]       CE;
    logic [LOSS_W-1:0]       LOSS_CNT;

    int n_tests = 0;
    int n_fail  = 0;

    ccc_lock_mgr #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_FILT(LOCK_FILT),
        .RST_HOLD(RST_HOLD), .LOSS_W(LOSS_W)
    ) dut (
        .CLK(CLK), .ARST_N(ARST_N), .LOCK_IN(LOCK_IN), .SW_RST(SW_RST),
        .CE_EN(CE_EN), .DIV(DIV), .RESET_OUT_N(RESET_OUT_N), .LOCKED(LOCKED),
        .CE(CE), .LOSS_CNT(LOSS_CNT)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model (phase-level) ----------------
    typedef enum int {M_WAIT, M_FILT, M_HOLD, M_RUN} mphase_t;
    mphase_t m_ph;
    int      m_sync[2];      // [0] first flop, [1] synchroniser output
    int      m_age;          // cycles already spent in the current FILTER/HOLD phase
    int      m_loss;
    int      m_ch[NUM_CH];   // per-channel divide counter

    function automatic void model_reset();
        m_ph = M_WAIT;
        m_sync[0] = 0; m_sync[1] = 0;
        m_age = 0; m_loss = 0;
        for (int i = 0; i < NUM_CH; i++) m_ch[i] = 0;
    endfunction

    function automatic void model_step();
        mphase_t nph = m_ph;
        int      nage = m_age + 1;
        bit      locked_now = (m_sync[1] != 0);
        if (m_ph != M_WAIT && !locked_now) begin
            nph = M_WAIT;
            if (m_ph == M_RUN) m_loss = (m_loss < LOSS_MAX) ? m_loss + 1 : LOSS_MAX;
        end else if (m_ph == M_WAIT && locked_now) begin
            nph = M_FILT;
        end else if (m_ph == M_FILT && nage == LOCK_FILT) begin
            nph = M_HOLD;
        end else if ((m_ph == M_HOLD || m_ph == M_RUN) && SW_RST) begin
            nph = M_HOLD;
            nage = 0;
        end else if (m_ph == M_HOLD && nage == RST_HOLD) begin
            nph = M_RUN;
        end
        if (nph != m_ph) nage = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            int d = int'(DIV[i*DIV_W +: DIV_W]);
            int period = (d < 2) ? 1 : d;
            if (m_ph != M_RUN || nph != M_RUN || !CE_EN[i]) m_ch[i] = 0;
            else m_ch[i] = (m_ch[i] + 1 >= period) ? 0 : m_ch[i] + 1;
        end
        m_sync[1] = m_sync[0];
        m_sync[0] = LOCK_IN ? 1 : 0;
        m_ph  = nph;
        m_age = (nph == M_WAIT) ? 0 : nage;
    endfunction

    function automatic logic [13:0] model_out();
        logic       run = (m_ph == M_RUN);
        logic [3:0] ce;
        for (int i = 0; i < NUM_CH; i++) ce[i] = run && CE_EN[i] && (m_ch[i] == 0);
        return {run, run, ce, LOSS_W'(m_loss)};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (!ARST_N) model_reset();
        else model_step();
        #1;
        check("model", {RESET_OUT_N, LOCKED, CE, LOSS_CNT}, model_out());
    endtask

    task automatic wait_run(input string name, input int bound);
        int n = 0;
        while (RESET_OUT_N !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check(name, RESET_OUT_N, 1'b1);
    endtask

    typedef struct {
        logic [31:0] div;
        logic [3:0]  en;
        int          exp_cnt[4];
    } vec_t;

    vec_t tbl[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt[4];
        int low_cyc;
        int ce_bad;
        int seg_left;

        tbl[0] = '{32'h0A_03_01_00, 4'b1111, '{30, 30, 10, 3}};
        tbl[1] = '{32'h04_FF_07_02, 4'b1111, '{15, 5, 1, 8}};
        tbl[2] = '{32'h09_00_06_05, 4'b0101, '{6, 0, 30, 0}};
        tbl[3] = '{32'h01_1F_1E_0B, 4'b1010, '{0, 1, 0, 30}};

        // reset state
        ARST_N = 1'b1; LOCK_IN = 1'b0; SW_RST = 1'b0; CE_EN = '0; DIV = '0;
        #1 ARST_N = 1'b0;
        model_reset();
        #1;
        check("reset_rst_n", RESET_OUT_N, 1'b0);
        check("reset_locked", LOCKED, 1'b0);
        check("reset_ce", CE, 4'h0);
        check("reset_loss", LOSS_CNT, 8'h00);
        tick(); tick();

        // lock present from edge 1: RUN after edge 27, every channel pulses in the first RUN cycle
        CE_EN = 4'b1111; DIV = 32'h0A_03_01_00;
        ARST_N = 1'b1; LOCK_IN = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            tick();
            if (k == 26) check("seq_edge26_low", RESET_OUT_N, 1'b0);
            if (k == 27) begin
                check("seq_edge27_rst", RESET_OUT_N, 1'b1);
                check("seq_edge27_locked", LOCKED, 1'b1);
                check("seq_first_ce", CE, 4'hF);
                check("seq_loss", LOSS_CNT, 8'h00);
            end
        end

        // CE divide table: count pulses over 30 cycles from an aligned start
        for (int e = 0; e < 4; e++) begin
            CE_EN = '0; DIV = tbl[e].div;
            tick();
            CE_EN = tbl[e].en;
            #1;
            for (int c = 0; c < 4; c++) cnt[c] = 0;
            for (int k = 0; k < 30; k++) begin
                for (int c = 0; c < 4; c++) cnt[c] += int'(CE[c]);
                tick();
            end
            for (int c = 0; c < 4; c++)
                check($sformatf("tbl%0d_ch%0d_pulses", e, c), cnt[c], tbl[e].exp_cnt[c]);
        end

        // channel disable and aligned restart
        DIV = 32'h0A_03_01_00; CE_EN = 4'b0111;
        tick(); tick(); tick();
        check("ce3_disabled", CE[3], 1'b0);
        CE_EN = 4'b1111;
        #1 check("ce3_reenable", CE[3], 1'b1);
        tick();

        // software reset pulse in RUN
        SW_RST = 1'b1;
        tick();
        SW_RST = 1'b0;
        low_cyc = 0; ce_bad = 0;
        while (RESET_OUT_N == 1'b0 && low_cyc < 100) begin
            low_cyc++;
            if (CE != 4'h0) ce_bad++;
            tick();
        end
        check("swrst_low_cycles", low_cyc, RST_HOLD);
        check("swrst_ce_held", ce_bad, 0);
        check("swrst_loss", LOSS_CNT, 8'h00);

        // repeated lock loss saturates the loss counter
        for (int d = 0; d < 300; d++) begin
            LOCK_IN = 1'b0;
            tick(); tick(); tick();
            check("drop_low_3edges", RESET_OUT_N, 1'b0);
            for (int k = 0; k < 7; k++) tick();
            LOCK_IN = 1'b1;
            wait_run("drop_recover", 60);
        end
        check("loss_saturated", LOSS_CNT, 8'hFF);

        // asynchronous reset in the middle of HOLD
        SW_RST = 1'b1;
        tick();
        SW_RST = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2 ARST_N = 1'b0;
        model_reset();
        #1;
        check("arst_rst_n", RESET_OUT_N, 1'b0);
        check("arst_locked", LOCKED, 1'b0);
        check("arst_ce", CE, 4'h0);
        check("arst_loss", LOSS_CNT, 8'h00);
        tick(); tick();

        // glitchy lock after restart: high 5, low 3, then steady
        ARST_N = 1'b1; LOCK_IN = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        LOCK_IN = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        LOCK_IN = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            tick();
            if (k == 26) check("glitch_edge26_low", RESET_OUT_N, 1'b0);
            if (k == 27) check("glitch_edge27_high", RESET_OUT_N, 1'b1);
        end
        check("glitch_loss", LOSS_CNT, 8'h00);

        // randomized traffic against the model
        seg_left = 40;
        for (int i = 0; i < 4000; i++) begin
            if (seg_left == 0) begin
                LOCK_IN = ~LOCK_IN;
                seg_left = LOCK_IN ? $urandom_range(1, 90) : $urandom_range(1, 12);
            end
            seg_left--;
            SW_RST = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) CE_EN = 4'($urandom_range(0, 15));
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 29) == 0) DIV[c*DIV_W +: DIV_W] = 8'($urandom_range(0, 12));
            if (i == 2000) begin
                ARST_N = 1'b0;
                model_reset();
                #1 check("rand_arst", {RESET_OUT_N, LOCKED, CE, LOSS_CNT}, model_out());
                tick();
                ARST_N = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ccc_lock_mgr.md
CCC_LOCK_MGR -- requirements
Module: ccc_lock_mgr

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of clock-enable channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 8, width of each channel divide value.
REQ-003 SHALL have parameter LOCK_FILT, default 256, consecutive synchronised LOCK-high cycles required to qualify lock (>=1).
REQ-004 SHALL have parameter RST_HOLD, default 64, cycles reset stays asserted after lock qualifies (>=1).
REQ-005 SHALL have parameter LOSS_W, default 8, width of lock-loss counter.
REQ-006 SHALL have port CLK  input  1  sole clock, the conditioned global clock (GL0 domain).
REQ-007 SHALL have port ARST_N  input  1  reset; one clock, asynchronous, active-low.
REQ-008 SHALL have port LOCK_IN  input  1  raw PLL lock, asynchronous to CLK.
REQ-009 SHALL have port SW_RST  input  1  synchronous request to re-run the reset hold sequence.
REQ-010 SHALL have port CE_EN  input  NUM_CH  per-channel enable.
REQ-011 SHALL have port DIV  input  NUM_CH*DIV_W  per-channel divide value; channel i occupies bits [i*DIV_W +: DIV_W].
REQ-012 SHALL have port RESET_OUT_N  output  1  system reset, low until the sequence completes.
REQ-013 SHALL have port LOCKED  output  1  qualified lock status.
REQ-014 SHALL have port CE  output  NUM_CH  per-channel one-cycle clock-enable pulses.
REQ-015 SHALL have port LOSS_CNT  output  LOSS_W  count of lock losses while in RUN.

Function
REQ-016 SHALL pass LOCK_IN through a 2-flop synchroniser; s2 denotes its output.
REQ-017 SHALL implement states WAIT_LOCK, FILTER, HOLD and RUN.
REQ-018 WAIT_LOCK: SHALL move to FILTER on the edge where s2=1, with the filter counter cleared to 0.
REQ-019 FILTER: SHALL increment the filter counter each cycle s2=1.
REQ-020 FILTER: SHALL move to HOLD on the edge where the counter = LOCK_FILT-1 and s2=1, so FILTER lasts exactly LOCK_FILT cycles.
REQ-021 FILTER: SHALL return to WAIT_LOCK on any cycle with s2=0.
REQ-022 HOLD: SHALL count RST_HOLD cycles, then move to RUN.
REQ-023 HOLD: SHALL go to WAIT_LOCK if s2=0; the hold counter restarts from 0 on each HOLD entry.
REQ-024 RUN: s2=0 SHALL move to WAIT_LOCK on the next edge and increment LOSS_CNT, saturating at 2^LOSS_W-1.
REQ-025 SW_RST=1 in RUN or HOLD SHALL move to HOLD with the counter cleared and no LOSS_CNT change.
REQ-026 SW_RST SHALL be ignored in WAIT_LOCK and FILTER.
REQ-027 Simultaneous s2=0 and SW_RST=1 in RUN SHALL resolve to the lock-loss path (REQ-024).
REQ-028 RESET_OUT_N and LOCKED SHALL be 1 exactly in cycles where the state register = RUN (registered, glitch-free); both SHALL be 0 otherwise.
REQ-029 Each channel SHALL have a DIV_W-bit counter held at 0 while not in RUN or while CE_EN[i]=0.
REQ-030 CE[i] SHALL be 1 when the state is RUN, CE_EN[i]=1 and the counter = 0.
REQ-031 The counter SHALL wrap to 0 when it is >= DIV[i]-1, else increment.
REQ-032 DIV[i] of 0 or 1 SHALL give CE[i]=1 every cycle; DIV[i]=N>=2 SHALL give one pulse every N cycles.
REQ-033 The first CE[i] pulse SHALL occur in the first RUN cycle.
REQ-034 A DIV change SHALL take effect at the counter comparison of the next cycle; if the new DIV-1 <= counter, the counter SHALL wrap on that edge.
REQ-035 All counters SHALL be sized to hold their terminal values without overflow.

Reset
REQ-036 ARST_N low SHALL asynchronously force: state WAIT_LOCK, synchroniser flops 0, all counters 0, RESET_OUT_N=0, LOCKED=0, CE=0, LOSS_CNT=0.
REQ-037 ARST_N deassertion SHALL be sampled synchronously; the first state update SHALL follow the first edge with ARST_N high.
REQ-038 ARST_N asserted mid-sequence SHALL discard all progress, including LOSS_CNT.

Verification
REQ-039 Scenario: LOCK_FILT=8, RST_HOLD=16, LOCK_IN high before edge 1 after reset release -> RESET_OUT_N and LOCKED rise after edge 27 (3+8+16), LOSS_CNT=0.
REQ-040 Scenario: LOCK_IN high 5 cycles, low 3, then steady high (LOCK_FILT=8) -> no HOLD entry during the glitch; RESET_OUT_N rises 27 edges after the final rise reaches the synchroniser input; LOSS_CNT stays 0.
REQ-041 Scenario: in RUN drop LOCK_IN 10 cycles, repeat 300 times with LOSS_W=8 -> RESET_OUT_N low within 3 edges of each drop; LOSS_CNT saturates at 255.
REQ-042 Scenario: NUM_CH=4, DIV={0,1,3,10}, all CE_EN=1 -> CE periods 1,1,3,10 cycles, all channels pulse in the first RUN cycle; CE_EN[3]=0 -> CE[3]=0, and restarts aligned at re-enable.
REQ-043 Scenario: SW_RST one-cycle pulse in RUN -> RESET_OUT_N low for exactly RST_HOLD cycles then high; CE held 0 meanwhile; LOSS_CNT unchanged.
REQ-044 Scenario: ARST_N pulsed low mid-HOLD -> all outputs 0 immediately (asynchronous); sequence restarts from WAIT_LOCK.
